riscv_lsu: RTL and testbench

- Load-store unit: the responder to the memory requests issued by the main decoder (mem_req, mem_we, mem_size).
- Core side: takes one load/store per instruction and holds the core via a stall signal until the access completes.
- Memory side: drives a word-addressed data-memory request/ready handshake, generates byte enables and lane-replicated write data, and sign/zero-extends load data.
- Catches misaligned and bad-size accesses, and memory timeouts, as faults.

---
 rtl/riscv_lsu.sv | 201 ++++++++++++++++++++
 tb/tb_riscv_lsu.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/riscv_lsu.sv
// Load-store unit: accepts one core load/store at a time, runs a word-addressed
// memory request/ready handshake and returns extended load data or a fault.
module riscv_lsu #(
  parameter int unsigned MEM_TIMEOUT = 32'd255
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        core_req_i,
  input  logic        core_we_i,
  input  logic [2:0]  core_size_i,
  input  logic [31:0] core_addr_i,
  input  logic [31:0] core_wd_i,
  output logic [31:0] core_rd_o,
  output logic        core_stall_o,
  output logic        lsu_fault_o,
  output logic        mem_req_o,
  output logic        mem_we_o,
  output logic [3:0]  mem_be_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wd_o,
  input  logic [31:0] mem_rd_i,
  input  logic        mem_ready_i
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_BUSY = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;

  localparam int unsigned CNT_W = (MEM_TIMEOUT > 32'd1) ? $clog2(MEM_TIMEOUT + 32'd1) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MEM_TIMEOUT - 32'd1);
  localparam logic TIMEOUT_EN = (MEM_TIMEOUT != 32'd0);

  function automatic logic size_legal(input logic [2:0] size, input logic [1:0] off);
    logic ok;
    case (size)
      3'd0, 3'd4: ok = 1'b1;
      3'd1, 3'd5: ok = (off[0] == 1'b0);
      3'd2:       ok = (off == 2'b00);
      default:    ok = 1'b0;
    endcase
    return ok;
  endfunction

  function automatic logic [3:0] byte_en(input logic [2:0] size, input logic [1:0] off);
    logic [3:0] be;
    case (size[1:0])
      2'd0:    be = 4'b0001 << off;
      2'd1:    be = 4'b0011 << off;
      2'd2:    be = 4'b1111;
      default: be = 4'b0000;
    endcase
    return be;
  endfunction

  function automatic logic [31:0] wr_data(input logic [2:0] size, input logic [31:0] wd);
    logic [31:0] d;
    case (size[1:0])
      2'd0:    d = {4{wd[7:0]}};
      2'd1:    d = {2{wd[15:0]}};
      default: d = wd;
    endcase
    return d;
  endfunction

  function automatic logic [31:0] load_ext(input logic [2:0] size, input logic [1:0] off,
                                           input logic [31:0] word);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    b = word[{off, 3'b000} +: 8];
    h = off[1] ? word[31:16] : word[15:0];
    case (size)
      3'd0:    r = {{24{b[7]}}, b};
      3'd4:    r = {24'd0, b};
      3'd1:    r = {{16{h[15]}}, h};
      3'd5:    r = {16'd0, h};
      3'd2:    r = word;
      default: r = 32'd0;
    endcase
    return r;
  endfunction

  logic [1:0]       state_r;
  logic [CNT_W-1:0] cnt_r;
  logic [2:0]       size_r;
  logic [1:0]       off_r;
  logic             mem_req_r;
  logic             mem_we_r;
  logic [3:0]       mem_be_r;
  logic [31:0]      mem_addr_r;
  logic [31:0]      mem_wd_r;
  logic [31:0]      rd_r;
  logic             tmo_fault_r;

  logic legal_s;
  logic timeout_s;
  logic stall_s;
  logic req_fault_s;

  // Access legality and timeout detection
  always_comb begin
    legal_s   = size_legal(core_size_i, core_addr_i[1:0]);
    timeout_s = TIMEOUT_EN && (cnt_r == CNT_LAST);
  end

  // Core-facing stall and request-fault; both forced low while in reset
  always_comb begin
    stall_s     = 1'b0;
    req_fault_s = 1'b0;
    if (rst_i) begin
      stall_s     = 1'b0;
      req_fault_s = 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (core_req_i) begin
            stall_s     = legal_s;
            req_fault_s = !legal_s;
          end else begin
            stall_s     = 1'b0;
            req_fault_s = 1'b0;
          end
        end
        ST_BUSY: stall_s = 1'b1;
        ST_RESP: stall_s = 1'b0;
        default: stall_s = 1'b0;
      endcase
    end
  end

  // FSM, captured request, memory outputs and load result
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_r     <= ST_IDLE;
      cnt_r       <= '0;
      size_r      <= 3'd0;
      off_r       <= 2'd0;
      mem_req_r   <= 1'b0;
      mem_we_r    <= 1'b0;
      mem_be_r    <= 4'd0;
      mem_addr_r  <= 32'd0;
      mem_wd_r    <= 32'd0;
      rd_r        <= 32'd0;
      tmo_fault_r <= 1'b0;
    end else begin
      tmo_fault_r <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (core_req_i && legal_s) begin
            state_r    <= ST_BUSY;
            cnt_r      <= '0;
            size_r     <= core_size_i;
            off_r      <= core_addr_i[1:0];
            mem_req_r  <= 1'b1;
            mem_we_r   <= core_we_i;
            mem_be_r   <= byte_en(core_size_i, core_addr_i[1:0]);
            mem_addr_r <= {core_addr_i[31:2], 2'b00};
            mem_wd_r   <= wr_data(core_size_i, core_wd_i);
          end else begin
            state_r <= ST_IDLE;
          end
        end
        ST_BUSY: begin
          if (mem_ready_i || timeout_s) begin
            state_r    <= ST_RESP;
            mem_req_r  <= 1'b0;
            mem_we_r   <= 1'b0;
            mem_be_r   <= 4'd0;
            mem_addr_r <= 32'd0;
            mem_wd_r   <= 32'd0;
            // A ready in the last allowed cycle still completes normally
            if (mem_ready_i) begin
              if (!mem_we_r) begin
                rd_r <= load_ext(size_r, off_r, mem_rd_i);
              end else begin
                rd_r <= rd_r;
              end
            end else begin
              tmo_fault_r <= 1'b1;
              rd_r        <= 32'd0;
            end
          end else begin
            cnt_r <= cnt_r + CNT_W'(1'b1);
          end
        end
        ST_RESP: state_r <= ST_IDLE;
        default: state_r <= ST_IDLE;
      endcase
    end
  end

  assign core_rd_o    = rd_r;
  assign core_stall_o = stall_s;
  assign lsu_fault_o  = req_fault_s | tmo_fault_r;
  assign mem_req_o    = mem_req_r;
  assign mem_we_o     = mem_we_r;
  assign mem_be_o     = mem_be_r;
  assign mem_addr_o   = mem_addr_r;
  assign mem_wd_o     = mem_wd_r;

endmodule

// File: tb/tb_riscv_lsu.sv
// Directed bench for riscv_lsu: table-driven single-cycle-ready accesses plus
// reset, timeout, delayed-ready and reset-abort sequences.
module tb_riscv_lsu;

  logic        clk;
  logic        rst;
  logic        req;
  logic        we;
  logic [2:0]  size;
  logic [31:0] addr;
  logic [31:0] wd;
  logic [31:0] mrd;
  logic        rdy;

  logic [31:0] core_rd;
  logic        stall;
  logic        fault;
  logic        mreq;
  logic        mwe;
  logic [3:0]  mbe;
  logic [31:0] maddr;
  logic [31:0] mwd;

  logic        req_t;
  logic [31:0] core_rd_t;
  logic        stall_t;
  logic        fault_t;
  logic        mreq_t;
  logic        mwe_t;
  logic [3:0]  mbe_t;
  logic [31:0] maddr_t;
  logic [31:0] mwd_t;

  int total = 0;
  int bad = 0;

  riscv_lsu dut (
    .clk_i(clk), .rst_i(rst), .core_req_i(req), .core_we_i(we), .core_size_i(size),
    .core_addr_i(addr), .core_wd_i(wd), .core_rd_o(core_rd), .core_stall_o(stall),
    .lsu_fault_o(fault), .mem_req_o(mreq), .mem_we_o(mwe), .mem_be_o(mbe),
    .mem_addr_o(maddr), .mem_wd_o(mwd), .mem_rd_i(mrd), .mem_ready_i(rdy)
  );

  riscv_lsu #(.MEM_TIMEOUT(4)) dut_to (
    .clk_i(clk), .rst_i(rst), .core_req_i(req_t), .core_we_i(we), .core_size_i(size),
    .core_addr_i(addr), .core_wd_i(wd), .core_rd_o(core_rd_t), .core_stall_o(stall_t),
    .lsu_fault_o(fault_t), .mem_req_o(mreq_t), .mem_we_o(mwe_t), .mem_be_o(mbe_t),
    .mem_addr_o(maddr_t), .mem_wd_o(mwd_t), .mem_rd_i(mrd), .mem_ready_i(1'b0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic [2:0]  size;
    logic [31:0] addr;
    logic [31:0] wd;
    logic [31:0] rdata;
    logic        fault;
    logic [3:0]  be;
    logic [31:0] mwd;
    logic [31:0] rd;
  } vec_t;

  vec_t vecs[13];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic vec_t mk(input logic v_we, input logic [2:0] v_size, input logic [31:0] v_addr,
                              input logic [31:0] v_wd, input logic [31:0] v_rdata, input logic v_fault,
                              input logic [3:0] v_be, input logic [31:0] v_mwd, input logic [31:0] v_rd);
    vec_t v;
    v.we = v_we; v.size = v_size; v.addr = v_addr; v.wd = v_wd; v.rdata = v_rdata;
    v.fault = v_fault; v.be = v_be; v.mwd = v_mwd; v.rd = v_rd;
    return v;
  endfunction

  initial begin
    vecs[0]  = mk(1'b1, 3'd0, 32'h0000_1003, 32'h1234_56AB, 32'h0,         1'b0, 4'b1000, 32'hABAB_ABAB, 32'h0);
    vecs[1]  = mk(1'b0, 3'd0, 32'h0000_0102, 32'h0,         32'h0080_0000, 1'b0, 4'b0100, 32'h0,         32'hFFFF_FF80);
    vecs[2]  = mk(1'b0, 3'd4, 32'h0000_0102, 32'h0,         32'h0080_0000, 1'b0, 4'b0100, 32'h0,         32'h0000_0080);
    vecs[3]  = mk(1'b0, 3'd5, 32'h0000_0102, 32'h0,         32'hBEEF_0000, 1'b0, 4'b1100, 32'h0,         32'h0000_BEEF);
    vecs[4]  = mk(1'b0, 3'd1, 32'h0000_0102, 32'h0,         32'hBEEF_0000, 1'b0, 4'b1100, 32'h0,         32'hFFFF_BEEF);
    vecs[5]  = mk(1'b1, 3'd1, 32'h0000_2002, 32'hCAFE_1234, 32'h0,         1'b0, 4'b1100, 32'h1234_1234, 32'h0);
    vecs[6]  = mk(1'b1, 3'd2, 32'h0000_3000, 32'hDEAD_BEEF, 32'h0,         1'b0, 4'b1111, 32'hDEAD_BEEF, 32'h0);
    vecs[7]  = mk(1'b0, 3'd2, 32'h0000_0101, 32'h0,         32'h0,         1'b1, 4'b0000, 32'h0,         32'h0);
    vecs[8]  = mk(1'b0, 3'd3, 32'h0000_0200, 32'h0,         32'h0,         1'b1, 4'b0000, 32'h0,         32'h0);
    vecs[9]  = mk(1'b1, 3'd1, 32'h0000_2001, 32'h5555_AAAA, 32'h0,         1'b1, 4'b0000, 32'h0,         32'h0);
    vecs[10] = mk(1'b0, 3'd0, 32'h0000_0003, 32'h0,         32'h7F00_0000, 1'b0, 4'b1000, 32'h0,         32'h0000_007F);
    vecs[11] = mk(1'b0, 3'd6, 32'h0000_0400, 32'h0,         32'h0,         1'b1, 4'b0000, 32'h0,         32'h0);
    vecs[12] = mk(1'b0, 3'd1, 32'h0000_0000, 32'h0,         32'h1234_8001, 1'b0, 4'b0011, 32'h0,         32'hFFFF_8001);

    // Reset held two cycles with a legal request pending
    rst = 1'b1; req = 1'b1; req_t = 1'b0; we = 1'b1; size = 3'd2;
    addr = 32'h0000_1000; wd = 32'hFFFF_FFFF; mrd = 32'h0; rdy = 1'b0;
    tick();
    tick();
    chk("rst_stall", {31'd0, stall}, 32'd0);
    chk("rst_mreq", {31'd0, mreq}, 32'd0);
    chk("rst_fault", {31'd0, fault}, 32'd0);
    chk("rst_rd", core_rd, 32'd0);
    chk("rst_mwe_be", {27'd0, mwe, mbe}, 32'd0);
    chk("rst_maddr", maddr, 32'd0);
    chk("rst_mwd", mwd, 32'd0);
    rst = 1'b0; req = 1'b0;
    #1;
    chk("idle_stall", {31'd0, stall}, 32'd0);
    tick();
    chk("idle_mreq", {31'd0, mreq}, 32'd0);
    chk("idle_stall2", {31'd0, stall}, 32'd0);

    // Table: one access each, ready in the first BUSY cycle
    for (int i = 0; i < 13; i++) begin
      req = 1'b1; we = vecs[i].we; size = vecs[i].size; addr = vecs[i].addr; wd = vecs[i].wd;
      #1;
      chk($sformatf("v%0d_fault", i), {31'd0, fault}, {31'd0, vecs[i].fault});
      chk($sformatf("v%0d_stall0", i), {31'd0, stall}, {31'd0, !vecs[i].fault});
      if (vecs[i].fault) begin
        tick();
        req = 1'b0;
        #1;
        chk($sformatf("v%0d_noreq", i), {31'd0, mreq}, 32'd0);
        chk($sformatf("v%0d_nofault", i), {31'd0, fault}, 32'd0);
      end else begin
        tick();
        req = 1'b0; addr = 32'hFFFF_FFFC; wd = 32'h0; rdy = 1'b1; mrd = vecs[i].rdata;
        #1;
        chk($sformatf("v%0d_busy", i), {30'd0, mreq, stall}, 32'd3);
        chk($sformatf("v%0d_we", i), {31'd0, mwe}, {31'd0, vecs[i].we});
        chk($sformatf("v%0d_be", i), {28'd0, mbe}, {28'd0, vecs[i].be});
        chk($sformatf("v%0d_addr", i), maddr, {vecs[i].addr[31:2], 2'b00});
        chk($sformatf("v%0d_mwd", i), mwd, vecs[i].mwd);
        tick();
        rdy = 1'b0;
        #1;
        chk($sformatf("v%0d_resp", i), {30'd0, mreq, stall}, 32'd0);
        if (!vecs[i].we) chk($sformatf("v%0d_rd", i), core_rd, vecs[i].rd);
        tick();
      end
    end

    // Timeout: MEM_TIMEOUT=4 instance never sees ready
    req_t = 1'b1; we = 1'b0; size = 3'd2; addr = 32'h0000_0040;
    #1;
    chk("to_stall0", {31'd0, stall_t}, 32'd1);
    tick();
    req_t = 1'b0;
    for (int c = 0; c < 4; c++) begin
      #1;
      chk($sformatf("to_busy%0d", c), {29'd0, mreq_t, fault_t, stall_t}, 32'b101);
      tick();
    end
    chk("to_resp", {29'd0, mreq_t, fault_t, stall_t}, 32'b010);
    chk("to_rd", core_rd_t, 32'd0);
    tick();
    chk("to_idle", {29'd0, mreq_t, fault_t, stall_t}, 32'b000);

    // Delayed ready with address changed mid-BUSY
    req = 1'b1; we = 1'b0; size = 3'd2; addr = 32'h0000_0200; mrd = 32'hA5A5_1234;
    #1;
    chk("dl_stall0", {31'd0, stall}, 32'd1);
    tick();
    req = 1'b0; addr = 32'h0000_0999;
    for (int c = 0; c < 5; c++) begin
      #1;
      chk($sformatf("dl_addr%0d", c), maddr, 32'h0000_0200);
      chk($sformatf("dl_busy%0d", c), {29'd0, mreq, fault, stall}, 32'b101);
      tick();
    end
    rdy = 1'b1;
    #1;
    chk("dl_addr_last", maddr, 32'h0000_0200);
    tick();
    rdy = 1'b0;
    #1;
    chk("dl_resp", {29'd0, mreq, fault, stall}, 32'b000);
    chk("dl_rd", core_rd, 32'hA5A5_1234);
    tick();

    // Reset during BUSY abandons the access
    req = 1'b1; size = 3'd2; addr = 32'h0000_0300;
    #1;
    tick();
    req = 1'b0;
    tick();
    chk("ra_busy", {31'd0, mreq}, 32'd1);
    rst = 1'b1;
    #1;
    chk("ra_stall_in_rst", {31'd0, stall}, 32'd0);
    tick();
    chk("ra_after", {29'd0, mreq, fault, stall}, 32'b000);
    rst = 1'b0;
    tick();
    chk("ra_idle", {29'd0, mreq, fault, stall}, 32'b000);
    chk("ra_rd", core_rd, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
